// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: byte-level I2C master for single register write/read transactions.
// Each bus action happens on a quarter-period tick; a bit slot is four quarters.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 312
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] devOut,
    input  logic [7:0] addrOut,
    input  logic [7:0] dataOut,
    output logic [7:0] dataIn,
    output logic       bsy,
    output logic       ok,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl
);

    localparam int               DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, START, SEND, RACK, RSTART, RECV, MNACK, STOP
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [1:0]       qcnt, qcnt_nxt;        // quarter within the current slot
    logic [2:0]       bit_cnt, bit_cnt_nxt;  // bit within the current byte
    logic [1:0]       byte_idx, byte_idx_nxt; // which acknowledged byte comes next
    logic [7:0]       shreg, shreg_nxt;
    logic             op_rd, op_rd_nxt;
    logic [6:0]       dev_r, dev_nxt;
    logic [7:0]       addr_r, addr_nxt;
    logic [7:0]       data_r, data_nxt;
    logic             nack, nack_nxt;
    logic             scl_nxt, sda_oe_nxt, bsy_nxt, ok_nxt;
    logic [7:0]       data_in_nxt;
    logic             qtick;

    assign qtick = (div_cnt == DIV_MAX);

    // Register update: synchronous reset aborts any transaction and releases the bus at once.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            qcnt     <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            op_rd    <= 1'b0;
            dev_r    <= '0;
            addr_r   <= '0;
            data_r   <= '0;
            nack     <= 1'b0;
            scl      <= 1'b1;
            sda_oe   <= 1'b0;
            bsy      <= 1'b0;
            ok       <= 1'b0;
            dataIn   <= '0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            qcnt     <= qcnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            byte_idx <= byte_idx_nxt;
            shreg    <= shreg_nxt;
            op_rd    <= op_rd_nxt;
            dev_r    <= dev_nxt;
            addr_r   <= addr_nxt;
            data_r   <= data_nxt;
            nack     <= nack_nxt;
            scl      <= scl_nxt;
            sda_oe   <= sda_oe_nxt;
            bsy      <= bsy_nxt;
            ok       <= ok_nxt;
            dataIn   <= data_in_nxt;
        end
    end

    // Next-state and next-output logic: accept in IDLE, otherwise advance one quarter per tick.
    always_comb begin
        // NOTE: every signal gets a hold default first, so no path through this block can infer a latch.
        state_nxt    = state;
        div_nxt      = qtick ? '0 : div_cnt + DIV_W'(1);
        qcnt_nxt     = qcnt;
        bit_cnt_nxt  = bit_cnt;
        byte_idx_nxt = byte_idx;
        shreg_nxt    = shreg;
        op_rd_nxt    = op_rd;
        dev_nxt      = dev_r;
        addr_nxt     = addr_r;
        data_nxt     = data_r;
        nack_nxt     = nack;
        scl_nxt      = scl;
        sda_oe_nxt   = sda_oe;
        bsy_nxt      = bsy;
        ok_nxt       = ok;
        data_in_nxt  = dataIn;

        if (state == IDLE) begin
            if (req) begin
                op_rd_nxt    = rw;
                dev_nxt      = devOut;
                addr_nxt     = addrOut;
                data_nxt     = dataOut;
                state_nxt    = START;
                bsy_nxt      = 1'b1;
                div_nxt      = '0;
                qcnt_nxt     = '0;
                bit_cnt_nxt  = '0;
                byte_idx_nxt = '0;
                nack_nxt     = 1'b0;
            end
        end else if (qtick) begin
            qcnt_nxt = qcnt + 2'd1;
            unique case (state)
                START, RSTART: begin
                    unique case (qcnt)
                        2'd0: begin sda_oe_nxt = 1'b0; scl_nxt = 1'b1; end
                        2'd1: sda_oe_nxt = 1'b1;   // SDA falls while SCL high
                        2'd2: scl_nxt = 1'b1;
                        2'd3: begin
                            scl_nxt   = 1'b0;
                            shreg_nxt = {dev_r, state == RSTART};
                            state_nxt = SEND;
                        end
                        default: ;
                    endcase
                end
                SEND: begin
                    unique case (qcnt)
                        2'd0: begin scl_nxt = 1'b0; sda_oe_nxt = ~shreg[7]; end
                        2'd1: scl_nxt = 1'b1;
                        2'd2: scl_nxt = 1'b1;
                        2'd3: begin
                            scl_nxt     = 1'b0;
                            shreg_nxt   = {shreg[6:0], 1'b0};
                            bit_cnt_nxt = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state_nxt = RACK;
                        end
                        default: ;
                    endcase
                end
                RACK: begin
                    unique case (qcnt)
                        2'd0: begin scl_nxt = 1'b0; sda_oe_nxt = 1'b0; end
                        2'd1: scl_nxt = 1'b1;
                        2'd2: begin
                            scl_nxt = 1'b1;
                            if (sda_in) nack_nxt = 1'b1;
                        end
                        2'd3: begin
                            scl_nxt      = 1'b0;
                            byte_idx_nxt = byte_idx + 2'd1;
                            if (nack) begin
                                state_nxt = STOP;
                            end else begin
                                unique case (byte_idx)
                                    2'd0: begin shreg_nxt = addr_r; state_nxt = SEND; end
                                    2'd1: begin
                                        if (op_rd) begin
                                            state_nxt = RSTART;
                                        end else begin
                                            shreg_nxt = data_r;
                                            state_nxt = SEND;
                                        end
                                    end
                                    default: state_nxt = op_rd ? RECV : STOP;
                                endcase
                            end
                        end
                        default: ;
                    endcase
                end
                RECV: begin
                    unique case (qcnt)
                        2'd0: begin scl_nxt = 1'b0; sda_oe_nxt = 1'b0; end
                        2'd1: scl_nxt = 1'b1;
                        2'd2: begin
                            scl_nxt   = 1'b1;
                            shreg_nxt = {shreg[6:0], sda_in};
                        end
                        2'd3: begin
                            scl_nxt     = 1'b0;
                            bit_cnt_nxt = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state_nxt = MNACK;
                        end
                        default: ;
                    endcase
                end
                MNACK: begin
                    unique case (qcnt)
                        2'd0: begin scl_nxt = 1'b0; sda_oe_nxt = 1'b0; end
                        2'd1: scl_nxt = 1'b1;
                        2'd2: scl_nxt = 1'b1;
                        2'd3: begin scl_nxt = 1'b0; state_nxt = STOP; end
                        default: ;
                    endcase
                end
                STOP: begin
                    unique case (qcnt)
                        2'd0: begin scl_nxt = 1'b0; sda_oe_nxt = 1'b1; end
                        2'd1: scl_nxt = 1'b1;
                        2'd2: sda_oe_nxt = 1'b0;   // SDA rises while SCL high
                        2'd3: begin
                            state_nxt = IDLE;
                            bsy_nxt   = 1'b0;
                            ok_nxt    = ~nack;
                            if (op_rd && !nack) data_in_nxt = shreg;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
